// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the fetch and data ports. A requester stalls with req held high until its ack.
// Loads ack RD_LAT+2 cycles after grant and stores ack 2 cycles after grant.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] m_raddress,
  output logic [ADDR_W-1:0] m_waddress,
  output logic [DATA_W-1:0] m_datain,
  input  logic [DATA_W-1:0] m_dataout,
  output logic              m_wr,
  output logic [1:0]        state_out
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              grantData, lastGrantData;
  logic              eligI, eligD, pickData, grant, complete;

  // A port in its ack cycle is not eligible, so a held req is not granted twice.
  assign eligI    = i_req & ~i_ack;
  assign eligD    = d_req & ~d_ack;
  assign pickData = eligD & (~eligI | ~lastGrantData);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    grant     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (eligI | eligD) begin
          grant     = 1'b1;
          cntNext   = CNT_W'(RD_LAT);
          stateNext = (pickData & d_we) ? WR : RD;
        end
      end
      RD: begin
        if (cnt != '0) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      WR:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addrQ         <= '0;
      wdataQ        <= '0;
      grantData     <= 1'b0;
      lastGrantData <= 1'b1;
      i_ack         <= 1'b0;
      d_ack         <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      i_ack <= complete & ~grantData;
      d_ack <= (complete & grantData) | (state == WR);
      if (grant) begin
        grantData     <= pickData;
        lastGrantData <= pickData;
        addrQ         <= pickData ? d_addr : i_addr;
        if (pickData) wdataQ <= d_wdata;
      end
      // Stores never reach here, so d_rdata only changes on loads.
      if (complete) begin
        if (grantData) d_rdata <= m_dataout;
        else           i_rdata <= m_dataout;
      end
    end
  end

  assign m_raddress = addrQ;
  assign m_waddress = addrQ;
  assign m_datain   = wdataQ;
  assign m_wr       = (state == WR);
  assign state_out  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [63:0] i_rdata, d_rdata, m_raddress, m_waddress, m_datain, m_dataout;
  logic        i_ack, d_ack, m_wr;
  logic [1:0]  state_out;

  logic        i_reqA = 1'b0, i_reqB = 1'b0;
  logic [63:0] i_addrF = 64'h10;
  logic [63:0] i_rdataA, i_rdataB, d_rdataA, d_rdataB, m_raA, m_raB, m_waA, m_waB;
  logic [63:0] m_diA, m_diB, m_doA, m_doB;
  logic        i_ackA, i_ackB, d_ackA, d_ackB, m_wrA, m_wrB;
  logic [1:0]  stA, stB;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_raddress(m_raddress), .m_waddress(m_waddress), .m_datain(m_datain), .m_dataout(m_dataout),
    .m_wr(m_wr), .state_out(state_out));

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(0)) dutA (
    .clk(clk), .reset(reset), .i_req(i_reqA), .i_addr(i_addrF), .i_rdata(i_rdataA), .i_ack(i_ackA),
    .d_req(1'b0), .d_we(1'b0), .d_addr(64'h0), .d_wdata(64'h0), .d_rdata(d_rdataA), .d_ack(d_ackA),
    .m_raddress(m_raA), .m_waddress(m_waA), .m_datain(m_diA), .m_dataout(m_doA),
    .m_wr(m_wrA), .state_out(stA));

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3)) dutB (
    .clk(clk), .reset(reset), .i_req(i_reqB), .i_addr(i_addrF), .i_rdata(i_rdataB), .i_ack(i_ackB),
    .d_req(1'b0), .d_we(1'b0), .d_addr(64'h0), .d_wdata(64'h0), .d_rdata(d_rdataB), .d_ack(d_ackB),
    .m_raddress(m_raB), .m_waddress(m_waB), .m_datain(m_diB), .m_dataout(m_doB),
    .m_wr(m_wrB), .state_out(stB));

  int nErr = 0, nChk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fmem(input logic [63:0] a);
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
  endfunction

  // Memories: main one is an array with one-cycle read delay; sweep instances use a fixed function.
  logic [63:0] mem [0:255];
  logic [63:0] modelMem [0:255];
  logic [7:0]  rdA1 = '0;
  logic [63:0] pB0 = '0, pB1 = '0, pB2 = '0;
  always @(posedge clk) begin
    rdA1 <= m_raddress[7:0];
    pB0  <= m_raB;
    pB1  <= pB0;
    pB2  <= pB1;
  end
  assign m_dataout = mem[rdA1];
  assign m_doA     = fmem(m_raA);
  assign m_doB     = fmem(pB2);

  // Reference model: one transaction at a time, scheduled by grant/ack cycle numbers.
  bit          inited = 0;
  int          cyc = 0;
  bit          mBusy = 0, mData = 0, mStore = 0, mLastD = 1;
  int          mGnt = 0, mAck = 0;
  logic [63:0] mAddr = '0, mWdata = '0, mVal = '0, expIR = '0, expDR = '0;

  always @(negedge clk) begin : model
    logic ai, ad, ei, ed, gD, expWr;
    int   expSt;
    if (!inited) begin
      for (int k = 0; k < 256; k++) begin
        mem[k]      = {$urandom, $urandom};
        modelMem[k] = mem[k];
      end
      mem[16]      = 64'h00500093;
      modelMem[16] = 64'h00500093;
      inited       = 1;
    end
    if (m_wr) mem[m_waddress[7:0]] = m_datain;

    ai = mBusy && (cyc == mAck) && !mData;
    ad = mBusy && (cyc == mAck) && mData;
    if (ai) expIR = mVal;
    if (ad && !mStore) expDR = mVal;
    expSt = (mBusy && cyc > mGnt && cyc < mAck) ? (mStore ? 2 : 1) : 0;
    expWr = mBusy && mStore && (cyc == mGnt + 1);

    chk("i_ack", 64'(i_ack), 64'(ai));
    chk("d_ack", 64'(d_ack), 64'(ad));
    chk("i_rdata", i_rdata, expIR);
    chk("d_rdata", d_rdata, expDR);
    chk("state_out", 64'(state_out), 64'(expSt));
    chk("m_wr", 64'(m_wr), 64'(expWr));
    chk("m_raddress", m_raddress, mAddr);
    chk("m_waddress", m_waddress, mAddr);
    if (expWr) chk("m_datain", m_datain, mWdata);

    if (ai || ad) mBusy = 0;
    if (reset) begin
      mBusy = 0; mLastD = 1; expIR = '0; expDR = '0; mAddr = '0; mWdata = '0;
    end else if (!mBusy) begin
      ei = i_req && !ai;
      ed = d_req && !ad;
      if (ei || ed) begin
        gD     = ed && (!ei || !mLastD);
        mBusy  = 1;
        mData  = gD;
        mLastD = gD;
        mGnt   = cyc;
        mStore = gD && d_we;
        mAddr  = gD ? d_addr : i_addr;
        if (gD) mWdata = d_wdata;
        if (mStore) begin
          modelMem[mAddr[7:0]] = mWdata;
          mAck = cyc + 2;
        end else begin
          mVal = modelMem[mAddr[7:0]];
          mAck = cyc + 2 + LAT;
        end
      end
    end
    cyc++;
  end

  // Per-run observation records (cycle index k counts from the start of the run).
  int          aC [8];
  int          aW [8];
  logic [63:0] aD [8];
  int          nA, nWr, wrC, nBusy, ackA, ackB, nAckAB;
  logic [63:0] wrAddr, wrData, rdA, rdB;

  task automatic resetDut();
    @(posedge clk); #1;
    reset = 1; i_req = 0; d_req = 0; d_we = 0; i_reqA = 0; i_reqB = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic run(input int n, input bit dropOnAck);
    bit dI, dD, dA, dB;
    nA = 0; nWr = 0; wrC = -1; nBusy = 0; ackA = -1; ackB = -1; nAckAB = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dI = 0; dD = 0; dA = 0; dB = 0;
      if (i_ack && nA < 8) begin aC[nA] = k; aW[nA] = 0; aD[nA] = i_rdata; nA++; dI = 1; end
      if (d_ack && nA < 8) begin aC[nA] = k; aW[nA] = 1; aD[nA] = d_rdata; nA++; dD = 1; end
      if (m_wr) begin
        nWr++;
        if (wrC < 0) begin wrC = k; wrAddr = m_waddress; wrData = m_datain; end
      end
      if (state_out != 2'd0) nBusy++;
      if (i_ackA) begin nAckAB++; if (ackA < 0) begin ackA = k; rdA = i_rdataA; end dA = 1; end
      if (i_ackB) begin nAckAB++; if (ackB < 0) begin ackB = k; rdB = i_rdataB; end dB = 1; end
      @(posedge clk); #1;
      if (dropOnAck) begin
        if (dI) i_req = 0;
        if (dD) d_req = 0;
        if (dA) i_reqA = 0;
        if (dB) i_reqB = 0;
      end
    end
  endtask

  initial begin : stim
    bit   iPend, dPend;
    logic ai, ad;

    @(negedge clk);
    chk("reset i_ack", 64'(i_ack), 64'h0);
    chk("reset d_ack", 64'(d_ack), 64'h0);
    chk("reset i_rdata", i_rdata, 64'h0);
    chk("reset d_rdata", d_rdata, 64'h0);
    chk("reset m_wr", 64'(m_wr), 64'h0);
    chk("reset state", 64'(state_out), 64'h0);

    // Single fetch on all three latencies.
    resetDut();
    i_req = 1; i_addr = 64'h10; i_reqA = 1; i_reqB = 1;
    run(8, 1);
    chk("fetch acks", 64'(nA), 64'd1);
    chk("fetch ack cycle", 64'(aC[0]), 64'd3);
    chk("fetch port", 64'(aW[0]), 64'd0);
    chk("fetch data", aD[0], 64'h00500093);
    chk("fetch no m_wr", 64'(nWr), 64'd0);
    chk("lat0 ack cycle", 64'(ackA), 64'd2);
    chk("lat0 data", rdA, fmem(64'h10));
    chk("lat3 ack cycle", 64'(ackB), 64'd5);
    chk("lat3 data", rdB, fmem(64'h10));
    chk("sweep ack count", 64'(nAckAB), 64'd2);
    @(negedge clk);
    chk("lat0 m_waddress", m_waA, 64'h10);
    chk("lat3 m_waddress", m_waB, 64'h10);
    chk("sweep m_datain", m_diA | m_diB, 64'h0);
    chk("sweep d_rdata", d_rdataA | d_rdataB, 64'h0);
    chk("sweep idle", {60'h0, stA, stB}, 64'h0);
    chk("sweep no d_ack/m_wr", {60'h0, d_ackA, d_ackB, m_wrA, m_wrB}, 64'h0);

    // Store then load, with requester data changed after the grant.
    resetDut();
    d_req = 1; d_we = 1; d_addr = 64'h20; d_wdata = 64'hDEADBEEF;
    run(1, 1);
    d_wdata = 64'h1111; d_addr = 64'h30;
    run(2, 1);
    chk("store m_wr count", 64'(nWr), 64'd1);
    chk("store m_wr cycle", 64'(wrC), 64'd0);
    chk("store m_waddress", wrAddr, 64'h20);
    chk("store m_datain", wrData, 64'hDEADBEEF);
    chk("store d_ack cycle", 64'(aC[0]), 64'd1);
    chk("store d_ack port", 64'(aW[0]), 64'd1);
    d_req = 1; d_we = 0; d_addr = 64'h20;
    run(5, 1);
    chk("load acks", 64'(nA), 64'd1);
    chk("load ack after grant", 64'(aC[0]), 64'd3);
    chk("load data", aD[0], 64'hDEADBEEF);

    // Continuous contention alternates, fetch first.
    resetDut();
    i_req = 1; i_addr = 64'h10; d_req = 1; d_we = 0; d_addr = 64'h20;
    run(14, 0);
    chk("contention ack count", 64'(nA), 64'd4);
    for (int j = 0; j < 4; j++) begin
      chk("contention ack cycle", 64'(aC[j]), 64'(3 + 3 * j));
      chk("contention ack port", 64'(aW[j]), 64'(j % 2));
    end

    // Fetch held across its ack: regrant waits one cycle.
    resetDut();
    i_req = 1; i_addr = 64'h10;
    run(9, 0);
    chk("held fetch ack count", 64'(nA), 64'd2);
    chk("held fetch ack1", 64'(aC[0]), 64'd3);
    chk("held fetch ack2", 64'(aC[1]), 64'd7);

    // Reset during RD of a fetch.
    resetDut();
    i_req = 1; i_addr = 64'h10;
    run(1, 0);
    reset = 1; i_req = 0;
    run(1, 0);
    chk("RD cycle busy", 64'(nBusy), 64'd1);
    reset = 0;
    run(6, 0);
    chk("RD reset no ack", 64'(nA), 64'd0);
    chk("RD reset idle", 64'(nBusy), 64'd0);

    // Reset during WR of a store.
    d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h55AA;
    run(1, 0);
    reset = 1; d_req = 0;
    run(1, 0);
    chk("WR cycle m_wr", 64'(nWr), 64'd1);
    reset = 0;
    run(6, 0);
    chk("WR reset m_wr low", 64'(nWr), 64'd0);
    chk("WR reset no ack", 64'(nA), 64'd0);
    chk("WR reset idle", 64'(nBusy), 64'd0);
    i_req = 1; i_addr = 64'h10; d_req = 1; d_we = 0; d_addr = 64'h20;
    run(4, 1);
    chk("post-reset first port", 64'(aW[0]), 64'd0);
    chk("post-reset first ack", 64'(aC[0]), 64'd3);

    // Randomized traffic with occasional resets; the model checks every cycle.
    resetDut();
    iPend = 0; dPend = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ai = i_ack; ad = d_ack;
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; iPend = 0; dPend = 0; i_req = 0; d_req = 0;
      end else begin
        reset = 0;
        if (ai) iPend = 0;
        if (ad) dPend = 0;
        if (!iPend && $urandom_range(0, 2) != 0) begin
          iPend = 1;
          i_addr = 64'($urandom_range(0, 31));
        end
        if (!dPend && $urandom_range(0, 2) != 0) begin
          dPend = 1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = 64'($urandom_range(0, 31));
          d_wdata = {$urandom, $urandom};
        end
        i_req = iPend; d_req = dPend;
      end
    end
    reset = 0; i_req = 0; d_req = 0;
    repeat (8) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    nErr++;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $fatal(1, "watchdog expired");
  end

endmodule
